// File: rtl/seq_bit_serializer_pkg.sv
// seq_bit_serializer_pkg: state encodings and default parameters shared by the serializer and sequence_fsm benches
package seq_bit_serializer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_GAP   = 0;
endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel word to framed serial stream with a programmable idle gap between words
// Ports: clk, rst (async, active-high); word_in/word_valid/word_ready accept handshake;
// data_out/bit_valid/frame_start registered serial outputs; busy high outside IDLE.
module seq_bit_serializer
  import seq_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  generate
    if (WIDTH < 2 || WIDTH > 32 || GAP < 0 || GAP > 15) begin : g_bad_param
      $error("seq_bit_serializer: WIDTH must be 2..32 and GAP 0..15");
    end
  endgenerate
  ser_state_e       state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             bit_last, gap_last, accept;
  assign bit_last = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign gap_last = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign accept   = word_valid && word_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  // Back-to-back accepts only happen on the last bit (GAP=0) or last gap cycle.
  always_comb
    state_nxt = accept                                ? ST_SHIFT :
                (state == ST_SHIFT && !bit_last)      ? ST_SHIFT :
                (bit_last && GAP > 0)                 ? ST_GAP   :
                (state == ST_GAP && !gap_last)        ? ST_GAP   : ST_IDLE;
  always_comb begin
    word_ready = !rst && (state == ST_IDLE || (bit_last && GAP == 0) || gap_last);
    busy       = state != ST_IDLE;
  end
  // The register holds the word so that the bit on data_out sits at the send end;
  // each step shifts it away and presents the neighbour.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sreg        <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      data_out    <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      gap_cnt <= (state == ST_GAP && !gap_last) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        sreg        <= word_in;
        bit_cnt     <= '0;
        data_out    <= MSB_FIRST ? word_in[WIDTH-1] : word_in[0];
        bit_valid   <= 1'b1;
        frame_start <= 1'b1;
      end else if (state == ST_SHIFT && !bit_last) begin
        sreg        <= MSB_FIRST ? sreg << 1 : sreg >> 1;
        bit_cnt     <= bit_cnt + 1'b1;
        data_out    <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
        bit_valid   <= 1'b1;
        frame_start <= 1'b0;
      end else begin
        bit_cnt     <= '0;
        data_out    <= 1'b0;
        bit_valid   <= 1'b0;
        frame_start <= 1'b0;
      end
    end
endmodule
